// File: rtl/hazard_light_ctrl.sv
// Hazard-light pattern controller: a 4-state lamp FSM steered by wind direction.
// Define HAZARD_PRESCALE_EN to advance once every TICK_DIV clocks instead of every clock.
module hazard_light_ctrl #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] wind,
  output logic [2:0] leds,
  output logic       step,
  output logic       wind_chg
);

  typedef enum logic [2:0] {
    S101 = 3'b101,
    S010 = 3'b010,
    S100 = 3'b100,
    S001 = 3'b001
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_wind_q;
  logic       r_step;
  logic       r_wind_chg;
  logic       w_tick;
  logic       w_calm;
  logic       w_l2r;

  if (TICK_DIV < 1 || TICK_DIV > 67108864) begin : g_bad_tick_div
    $error("hazard_light_ctrl: TICK_DIV out of range 1..2^26");
  end

`ifdef HAZARD_PRESCALE_EN
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tick = (r_cnt == CNT_MAX);
`else
  assign w_tick = 1'b1;
`endif

  // 11 is an unused encoding and behaves exactly like calm.
  assign w_calm = (wind == 2'b00) || (wind == 2'b11);
  assign w_l2r  = (wind == 2'b10);

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S101;
      r_wind_q   <= 2'b00;
      r_step     <= 1'b0;
      r_wind_chg <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wind_q   <= wind;
      r_step     <= w_tick;
      r_wind_chg <= (wind != r_wind_q);
    end
  end

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S101: if (w_tick) w_next = w_calm ? S010 : (w_l2r ? S100 : S001);
      S010: if (w_tick) w_next = w_calm ? S101 : (w_l2r ? S001 : S100);
      S100: if (w_tick) w_next = w_calm ? S010 : (w_l2r ? S010 : S001);
      S001: if (w_tick) w_next = w_calm ? S010 : (w_l2r ? S100 : S010);
      // Corrupted codes recover on the very next clock, tick or not.
      default: w_next = S101;
    endcase
  end

  assign leds     = r_state;
  assign step     = r_step;
  assign wind_chg = r_wind_chg;

endmodule

// File: tb/tb_hazard_light_ctrl.sv
// Self-checking bench for hazard_light_ctrl: vector table, corner sequences and
// randomized wind against a ring-based reference model; honours HAZARD_PRESCALE_EN.
module tb_hazard_light_ctrl;

`ifdef HAZARD_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic       clk;
  logic       reset_n;
  logic [1:0] wind;
  logic [2:0] leds;
  logic       step;
  logic       wind_chg;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [2:0] m_leds;
  logic       m_step;
  logic       m_chg;
  logic [1:0] m_wq;
  int         k;

  typedef struct {
    logic [1:0] w;
    logic [2:0] exp_leds;
  } vec_t;

  vec_t vecs [17];

  hazard_light_ctrl #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wind     (wind),
    .leds     (leds),
    .step     (step),
    .wind_chg (wind_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Calm toggles between 101 and 010; directional winds walk a 3-lamp ring,
  // entering it at the ring head when coming from 101.
  function automatic logic [2:0] next_leds(input logic [2:0] cur, input logic [1:0] w);
    logic [2:0] ring [3];
    if (!(cur == 3'b101 || cur == 3'b010 || cur == 3'b100 || cur == 3'b001)) return 3'b101;
    if (w == 2'b00 || w == 2'b11) return (cur == 3'b010) ? 3'b101 : 3'b010;
    if (w == 2'b10) begin
      ring[0] = 3'b100; ring[1] = 3'b010; ring[2] = 3'b001;
    end else begin
      ring[0] = 3'b001; ring[1] = 3'b010; ring[2] = 3'b100;
    end
    if (cur == 3'b101) return ring[0];
    for (int i = 0; i < 3; i++)
      if (ring[i] == cur) return ring[(i + 1) % 3];
    return 3'b101;
  endfunction

  task automatic cycle(input logic [1:0] w);
    bit tick;
    wind = w;
    @(posedge clk);
    k++;
    tick   = ((k % P) == 0);
    m_chg  = (w != m_wq);
    m_wq   = w;
    m_step = tick;
    if (tick) m_leds = next_leds(m_leds, w);
    #1;
    check("leds", {29'd0, leds}, {29'd0, m_leds});
    check("step", {31'd0, step}, {31'd0, m_step});
    check("wind_chg", {31'd0, wind_chg}, {31'd0, m_chg});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    m_leds = 3'b101; m_step = 1'b0; m_chg = 1'b0; m_wq = 2'b00; k = 0;
    check("reset leds", {29'd0, leds}, 32'h5);
    check("reset step", {31'd0, step}, 32'h0);
    check("reset wind_chg", {31'd0, wind_chg}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int guard;
    int edges;
    int pulses;
    int extra;

    vecs[0]  = '{2'b10, 3'b100};
    vecs[1]  = '{2'b10, 3'b010};
    vecs[2]  = '{2'b10, 3'b001};
    vecs[3]  = '{2'b10, 3'b100};
    vecs[4]  = '{2'b10, 3'b010};
    vecs[5]  = '{2'b01, 3'b100};
    vecs[6]  = '{2'b01, 3'b001};
    vecs[7]  = '{2'b01, 3'b010};
    vecs[8]  = '{2'b01, 3'b100};
    vecs[9]  = '{2'b00, 3'b010};
    vecs[10] = '{2'b11, 3'b101};
    vecs[11] = '{2'b01, 3'b001};
    vecs[12] = '{2'b00, 3'b010};
    vecs[13] = '{2'b10, 3'b001};
    vecs[14] = '{2'b11, 3'b010};
    vecs[15] = '{2'b00, 3'b101};
    vecs[16] = '{2'b10, 3'b100};

    reset_n = 1'b1;
    wind    = 2'b00;
    m_leds = 3'b101; m_step = 1'b0; m_chg = 1'b0; m_wq = 2'b00; k = 0;
    #2;
    do_reset();

    // Each vector holds the wind for exactly one tick period.
    foreach (vecs[i]) begin
      repeat (P) cycle(vecs[i].w);
      check($sformatf("table[%0d] leds", i), {29'd0, leds}, {29'd0, vecs[i].exp_leds});
    end

    // Wind flips 10 -> 01 in the tick cycle while in 010: new wind wins.
    guard = 0;
    while (m_leds != 3'b010 && guard < 20 * P) begin
      cycle(2'b10);
      guard++;
    end
    check("reach 010", {29'd0, leds}, 32'h2);
    repeat (P - 1) cycle(2'b10);
    cycle(2'b01);
    check("flip in tick leds", {29'd0, leds}, 32'h4);
    check("flip in tick wind_chg", {31'd0, wind_chg}, 32'h1);
    cycle(2'b01);
    check("flip wind_chg drops", {31'd0, wind_chg}, 32'h0);

    // Calm 00 -> 11 -> 00: two change pulses, toggling undisturbed.
    repeat (2 * P) cycle(2'b00);
    pulses = 0;
    repeat (2 * P) begin
      cycle(2'b11);
      if (wind_chg) pulses++;
    end
    repeat (2 * P) begin
      cycle(2'b00);
      if (wind_chg) pulses++;
    end
    check("calm encoding pulses", pulses, 2);

    // Reset mid-count while showing 001, then time the first change.
    guard = 0;
    while (m_leds != 3'b001 && guard < 20 * P) begin
      cycle(2'b10);
      guard++;
    end
    check("reach 001", {29'd0, leds}, 32'h1);
    extra = (P > 2) ? 2 : P - 1;
    repeat (extra) cycle(2'b10);
    do_reset();
    edges = 0;
    for (int i = 1; i <= 4 * P + 4; i++) begin
      cycle(2'b00);
      if (leds != 3'b101) begin
        edges = i;
        break;
      end
    end
    check("first change after reset", edges, P);

    // Wind held at 10 through reset pulses wind_chg right after release.
    wind = 2'b10;
    do_reset();
    cycle(2'b10);
    check("wind_chg after release", {31'd0, wind_chg}, 32'h1);

    // Randomized wind with random hold lengths and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] w;
      int hold;
      w    = 2'($urandom_range(3, 0));
      hold = $urandom_range(3 * P, 1);
      if ($urandom_range(39, 0) == 0) begin
        wind = w;
        do_reset();
      end
      repeat (hold) cycle(w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
